icu: RTL and testbench

- Instruction cache unit sitting directly downstream of the fetch-PC stage (ifu) and upstream of decode (idu).
- Accepts {pc, snpc} plus a misalignment flag over valid/ready.
- Looks up a direct-mapped, one-word-per-line instruction cache; on a miss, fetches the word over an AXI4-Lite read channel.
- Emits {pc, snpc, inst} plus exception flags to idu over valid/ready. Honours branch/exception/mret flushes and fence.i invalidation.

---
 rtl/icu.sv | 247 ++++++++++++++++++++++++
 tb/tb_icu.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/icu.sv
// ============================================================================
// icu -- instruction cache unit
//
// Sits between the fetch-PC stage (ifu) and decode (idu). A request
// {pc, snpc} is looked up in a direct-mapped cache that holds one 32-bit
// instruction per line. On a miss the word is fetched over an AXI4-Lite
// read channel. The result {pc, snpc, inst} and the exception flags go to
// idu through a registered valid/ready output stage.
//
// Ports:
//   clock, reset        system clock; synchronous active-high reset
//   branch_flush,
//   excp_flush,
//   mret_flush          any of these kills the in-flight instruction
//   fence_i             one-cycle pulse that invalidates every line
//   valid_i / ready_o   upstream handshake
//   ifu_icu_bus_i       {pc[31:0], snpc[31:0]}
//   ifu_excp_bus_i      pc misaligned
//   valid_o / ready_i   downstream handshake
//   icu_idu_bus_o       {pc, snpc, inst}
//   icu_excp_bus_o      bit0 = fetch misaligned, bit1 = access fault
//   araddr, arvalid,
//   arready             AXI4-Lite read address channel
//   rdata, rresp,
//   rvalid, rready      AXI4-Lite read data channel
// ============================================================================
module icu #(
    parameter int INDEX_BITS = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        branch_flush,
    input  logic        excp_flush,
    input  logic        mret_flush,
    input  logic        fence_i,
    input  logic        valid_i,
    input  logic [63:0] ifu_icu_bus_i,
    input  logic        ifu_excp_bus_i,
    output logic        ready_o,
    output logic        valid_o,
    output logic [95:0] icu_idu_bus_o,
    output logic [1:0]  icu_excp_bus_o,
    input  logic        ready_i,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready
);

    localparam int TAG_BITS = 30 - INDEX_BITS;
    localparam int LINES    = 1 << INDEX_BITS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_DRAIN
    } state_t;

    state_t                state_q, state_d;
    logic                  out_valid_q, out_valid_d;
    logic [95:0]           out_bus_q, out_bus_d;
    logic [1:0]            out_excp_q, out_excp_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q, rready_d;
    logic                  fence_pending_q, fence_pending_d;
    logic [31:0]           pc_q, pc_d;
    logic [31:0]           snpc_q, snpc_d;
    logic [LINES-1:0]      line_valid_q, line_valid_d;
    logic [TAG_BITS-1:0]   tag_q [LINES];
    logic [TAG_BITS-1:0]   tag_d [LINES];
    logic [31:0]           data_q [LINES];
    logic [31:0]           data_d [LINES];

    logic                  flush;
    logic [31:0]           req_pc;
    logic [31:0]           req_snpc;
    logic [INDEX_BITS-1:0] req_idx;
    logic [TAG_BITS-1:0]   req_tag;
    logic                  lookup_hit;
    logic                  accept;
    logic [INDEX_BITS-1:0] fill_idx;
    logic                  refill;

    // Request decode, lookup and the upstream ready. Requests are only taken
    // in IDLE when the output slot is free (or being drained this cycle) and
    // no flush or invalidation is in progress.
    always_comb begin
        flush      = branch_flush | excp_flush | mret_flush;
        req_pc     = ifu_icu_bus_i[63:32];
        req_snpc   = ifu_icu_bus_i[31:0];
        req_idx    = req_pc[INDEX_BITS+1:2];
        req_tag    = req_pc[31:2+INDEX_BITS];
        lookup_hit = line_valid_q[req_idx] && (tag_q[req_idx] == req_tag);
        ready_o    = (state_q == S_IDLE) && (!out_valid_q || ready_i)
                     && !fence_pending_q && !fence_i && !flush;
        accept     = valid_i && ready_o;
        fill_idx   = pc_q[INDEX_BITS+1:2];
    end

    // Next-state logic. A killed miss is not abandoned on the bus: DRAIN
    // finishes whichever handshakes remain so only one transaction is ever
    // outstanding, and an OKAY response still refills the line.
    always_comb begin
        state_d         = state_q;
        arvalid_d       = arvalid_q;
        rready_d        = rready_q;
        pc_d            = pc_q;
        snpc_d          = snpc_q;
        out_bus_d       = out_bus_q;
        out_excp_d      = out_excp_q;
        fence_pending_d = fence_pending_q;
        line_valid_d    = line_valid_q;
        tag_d           = tag_q;
        data_d          = data_q;
        refill          = 1'b0;

        if (flush) begin
            out_valid_d = 1'b0;
        end else if (out_valid_q && ready_i) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    pc_d   = req_pc;
                    snpc_d = req_snpc;
                    if (ifu_excp_bus_i) begin
                        out_valid_d = 1'b1;
                        out_bus_d   = {req_pc, req_snpc, 32'h0};
                        out_excp_d  = 2'b01;
                    end else if (lookup_hit) begin
                        out_valid_d = 1'b1;
                        out_bus_d   = {req_pc, req_snpc, data_q[req_idx]};
                        out_excp_d  = 2'b00;
                    end else begin
                        state_d   = S_AR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            S_AR: begin
                if (arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = flush ? S_DRAIN : S_R;
                end else if (flush) begin
                    state_d = S_DRAIN;
                end
            end
            S_R: begin
                if (rvalid) begin
                    rready_d = 1'b0;
                    state_d  = S_IDLE;
                    refill   = (rresp == 2'b00);
                    if (!flush) begin
                        out_valid_d = 1'b1;
                        out_bus_d   = {pc_q, snpc_q,
                                       (rresp == 2'b00) ? rdata : 32'h0};
                        out_excp_d  = (rresp == 2'b00) ? 2'b00 : 2'b10;
                    end
                end else if (flush) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (arvalid_q && arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
                if (rready_q && rvalid) begin
                    rready_d = 1'b0;
                    state_d  = S_IDLE;
                    refill   = (rresp == 2'b00);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (refill) begin
            line_valid_d[fill_idx] = 1'b1;
            tag_d[fill_idx]        = pc_q[31:2+INDEX_BITS];
            data_d[fill_idx]       = rdata;
        end

        // Invalidation is applied last so it wins over a same-cycle refill.
        // Outside IDLE it is deferred to the first IDLE cycle.
        if (state_q == S_IDLE) begin
            if (fence_i || fence_pending_q) begin
                line_valid_d = '0;
            end
            fence_pending_d = 1'b0;
        end else if (fence_i) begin
            fence_pending_d = 1'b1;
        end
    end

    // Single state register for the FSM, the cache arrays and the outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= S_IDLE;
            out_valid_q     <= 1'b0;
            out_bus_q       <= '0;
            out_excp_q      <= '0;
            arvalid_q       <= 1'b0;
            rready_q        <= 1'b0;
            fence_pending_q <= 1'b0;
            pc_q            <= '0;
            snpc_q          <= '0;
            line_valid_q    <= '0;
            tag_q           <= '{default: '0};
            data_q          <= '{default: '0};
        end else begin
            state_q         <= state_d;
            out_valid_q     <= out_valid_d;
            out_bus_q       <= out_bus_d;
            out_excp_q      <= out_excp_d;
            arvalid_q       <= arvalid_d;
            rready_q        <= rready_d;
            fence_pending_q <= fence_pending_d;
            pc_q            <= pc_d;
            snpc_q          <= snpc_d;
            line_valid_q    <= line_valid_d;
            tag_q           <= tag_d;
            data_q          <= data_d;
        end
    end

    // The output is killed combinationally in a flush cycle.
    always_comb begin
        valid_o        = out_valid_q && !flush;
        icu_idu_bus_o  = out_bus_q;
        icu_excp_bus_o = out_excp_q;
        araddr         = {pc_q[31:2], 2'b00};
        arvalid        = arvalid_q;
        rready         = rready_q;
    end

endmodule

// File: tb/tb_icu.sv
// ============================================================================
// tb_icu -- self-checking bench for icu.
//
// The bench plays both the fetch stage and the AXI4-Lite slave. A small
// cache model (valid/tag/data per line) predicts hit or miss for every
// request and the expected output word and flags.
// ============================================================================
module tb_icu;

    localparam int IB    = 4;
    localparam int LINES = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic        branch_flush, excp_flush, mret_flush, fence_i;
    logic        valid_i, ready_o, valid_o, ready_i;
    logic [63:0] ifu_icu_bus_i;
    logic        ifu_excp_bus_i;
    logic [95:0] icu_idu_bus_o;
    logic [1:0]  icu_excp_bus_o;
    logic [31:0] araddr, rdata;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  rresp;

    int checks = 0;
    int errors = 0;

    bit          m_valid [LINES];
    int unsigned m_tag   [LINES];
    logic [31:0] m_data  [LINES];

    icu #(.INDEX_BITS(IB)) dut (
        .clock          (clock),
        .reset          (reset),
        .branch_flush   (branch_flush),
        .excp_flush     (excp_flush),
        .mret_flush     (mret_flush),
        .fence_i        (fence_i),
        .valid_i        (valid_i),
        .ifu_icu_bus_i  (ifu_icu_bus_i),
        .ifu_excp_bus_i (ifu_excp_bus_i),
        .ready_o        (ready_o),
        .valid_o        (valid_o),
        .icu_idu_bus_o  (icu_idu_bus_o),
        .icu_excp_bus_o (icu_excp_bus_o),
        .ready_i        (ready_i),
        .araddr         (araddr),
        .arvalid        (arvalid),
        .arready        (arready),
        .rdata          (rdata),
        .rresp          (rresp),
        .rvalid         (rvalid),
        .rready         (rready)
    );

    always #5 clock = ~clock;

    // One comparison: counts it, and on a difference counts and reports it.
    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One fetch. mode: 0 plain, 1 flush while waiting in R, 2 fence_i during
    // the miss, 3 flush together with rvalid, 4 flush while in AR.
    // hold: extra cycles of downstream backpressure on a produced output.
    task automatic applyStimulus(input logic [31:0] pc, input bit mis,
                                 input logic [1:0] resp, input logic [31:0] data,
                                 input int ar_dly, input int r_dly,
                                 input int mode, input int hold);
        int unsigned idx;
        int unsigned tag;
        bit          hit;
        bit          show;
        logic [31:0] inst;
        logic [1:0]  excp;
        logic [31:0] waddr;

        idx   = (pc >> 2) % LINES;
        tag   = pc >> (2 + IB);
        hit   = !mis && m_valid[idx] && (m_tag[idx] == tag);
        waddr = pc & ~32'd3;
        show  = 1'b1;
        inst  = 32'h0;
        excp  = 2'b00;

        @(negedge clock);
        valid_i        = 1'b1;
        ifu_icu_bus_i  = {pc, pc + 32'd4};
        ifu_excp_bus_i = mis;
        ready_i        = (hold == 0);
        #1 checkOutput("accept_ready", ready_o, 1);
        @(negedge clock);
        valid_i        = 1'b0;
        ifu_excp_bus_i = 1'b0;
        #1;
        if (mis || hit) begin
            checkOutput("no_axi", {arvalid, rready}, 0);
            inst = mis ? 32'h0 : m_data[idx];
            excp = mis ? 2'b01 : 2'b00;
        end else begin
            checkOutput("ar_start", {arvalid, araddr}, {1'b1, waddr});
            checkOutput("miss_no_valid", valid_o, 0);
            if (mode == 4) begin
                excp_flush = 1'b1;
                @(negedge clock);
                excp_flush = 1'b0;
                #1 checkOutput("drain_arvalid", {arvalid, araddr}, {1'b1, waddr});
            end
            for (int i = 0; i < ar_dly; i++) begin
                @(negedge clock);
                #1 checkOutput("ar_hold", {arvalid, araddr}, {1'b1, waddr});
            end
            arready = 1'b1;
            if (mode == 2) fence_i = 1'b1;
            @(negedge clock);
            arready = 1'b0;
            fence_i = 1'b0;
            #1 checkOutput("r_phase", {arvalid, rready}, 2'b01);
            repeat (r_dly) @(negedge clock);
            if (mode == 1) begin
                branch_flush = 1'b1;
                #1 checkOutput("flush_no_out", {valid_o, ready_o}, 0);
                @(negedge clock);
                branch_flush = 1'b0;
            end
            rvalid = 1'b1;
            rdata  = data;
            rresp  = resp;
            if (mode == 3) mret_flush = 1'b1;
            @(negedge clock);
            rvalid     = 1'b0;
            mret_flush = 1'b0;
            rdata      = $urandom;
            rresp      = 2'b00;
            #1;
            if (resp == 2'b00) begin
                m_valid[idx] = 1'b1;
                m_tag[idx]   = tag;
                m_data[idx]  = data;
            end
            inst = (resp == 2'b00) ? data : 32'h0;
            excp = (resp == 2'b00) ? 2'b00 : 2'b10;
            show = (mode == 0) || (mode == 2);
            if (!show) begin
                checkOutput("killed", {valid_o, ready_o, rready, arvalid}, 4'b0100);
            end else if (mode == 2) begin
                checkOutput("fence_ready_low", ready_o, 0);
                for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
            end
        end
        if (show) begin
            checkOutput("out_valid", valid_o, 1);
            checkOutput("out_bus", {icu_idu_bus_o, icu_excp_bus_o},
                        {pc, pc + 32'd4, inst, excp});
            for (int i = 0; i < hold; i++) begin
                @(negedge clock);
                #1 checkOutput("bp_hold",
                               {valid_o, ready_o, icu_idu_bus_o, icu_excp_bus_o},
                               {1'b1, 1'b0, pc, pc + 32'd4, inst, excp});
            end
        end
        ready_i = 1'b1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] rpc;
        bit          rmis;
        logic [1:0]  rresp_sel;

        reset          = 1'b1;
        branch_flush   = 1'b0;
        excp_flush     = 1'b0;
        mret_flush     = 1'b0;
        fence_i        = 1'b0;
        valid_i        = 1'b0;
        ifu_icu_bus_i  = '0;
        ifu_excp_bus_i = 1'b0;
        ready_i        = 1'b1;
        arready        = 1'b0;
        rdata          = '0;
        rresp          = 2'b00;
        rvalid         = 1'b0;
        for (int i = 0; i < LINES; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 0;
            m_data[i]  = '0;
        end

        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        checkOutput("reset_outs", {valid_o, arvalid, rready, icu_idu_bus_o, icu_excp_bus_o}, 0);
        checkOutput("reset_ready", ready_o, 1);

        $display("[TB] directed sequence");
        applyStimulus(32'h3000_0000, 0, 2'b00, 32'h0000_0413, 0, 1, 0, 0);
        applyStimulus(32'h3000_0000, 0, 2'b00, 32'h0, 0, 0, 0, 0);
        applyStimulus(32'h3000_0000, 0, 2'b00, 32'h0, 0, 0, 0, 5);
        applyStimulus(32'h3000_0040, 0, 2'b00, 32'h1234_5678, 1, 0, 0, 0);
        applyStimulus(32'h3000_0000, 0, 2'b00, 32'h0000_0413, 0, 2, 0, 0);
        applyStimulus(32'h3000_0002, 1, 2'b00, 32'h0, 0, 0, 0, 0);
        applyStimulus(32'h3000_0010, 0, 2'b10, 32'hdead_beef, 0, 0, 0, 0);
        applyStimulus(32'h3000_0010, 0, 2'b00, 32'h0000_0013, 0, 0, 0, 0);
        applyStimulus(32'h3000_0020, 0, 2'b00, 32'hcafe_0001, 0, 1, 1, 0);
        applyStimulus(32'h3000_0020, 0, 2'b00, 32'h0, 0, 0, 0, 0);
        applyStimulus(32'h3000_0024, 0, 2'b00, 32'hcafe_0002, 1, 1, 2, 0);
        applyStimulus(32'h3000_0024, 0, 2'b00, 32'hcafe_0003, 0, 0, 0, 0);
        applyStimulus(32'h3000_0028, 0, 2'b00, 32'hcafe_0004, 0, 0, 3, 0);
        applyStimulus(32'h3000_002c, 0, 2'b00, 32'hcafe_0005, 2, 0, 4, 0);
        applyStimulus(32'h3000_0028, 0, 2'b00, 32'h0, 0, 0, 0, 2);

        $display("[TB] randomized sequence");
        for (int n = 0; n < 60; n++) begin
            rpc  = 32'h3000_0000 | ($urandom_range(0, 1) << 6) | ($urandom_range(0, 3) << 2);
            rmis = ($urandom_range(0, 7) == 0);
            if (rmis) rpc = rpc | 32'd2;
            rresp_sel = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            applyStimulus(rpc, rmis, rresp_sel, $urandom, $urandom_range(0, 2),
                          $urandom_range(0, 2), $urandom_range(0, 4), $urandom_range(0, 2));
        end

        @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
